adc_avg_fifo: RTL and testbench

ADC_AVG_FIFO -- requirements
Module: adc_avg_fifo

---
 rtl/adc_avg_fifo.sv | 105 ++++++++++
 tb/tb_adc_avg_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_fifo.sv
// ADC sample averager: accumulates 2^AVG_LOG2 captured samples, writes the
// truncated mean into a 2^FIFO_LOG2-word FIFO with sticky overflow on drops.
module adc_avg_fifo #(
  parameter int AVG_LOG2  = 2,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk_100,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 sample_cs,
  input  logic [15:0]          sample_data,
  input  logic                 rd_en,
  input  logic                 clr_ovf,
  output logic [15:0]          rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic [FIFO_LOG2:0]   count,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int ACC_W = 16 + AVG_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);

  logic                 cs_d;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [AVG_LOG2-1:0]  smp_cnt;
  logic                 capture;
  logic                 blk_done;
  logic [15:0]          avg;

  logic [15:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic                 pop;
  logic                 wr_ok;
  logic                 wr_drop;

  assign capture  = sample_cs & ~cs_d & sample_en;
  assign acc_sum  = acc + ACC_W'(sample_data);
  assign blk_done = capture && (smp_cnt == '1);
  // Top 16 bits of the full-block sum is the mean truncated by 2^AVG_LOG2.
  assign avg      = acc_sum[ACC_W-1 -: 16];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot the new word lands in.
  assign wr_ok   = blk_done & (~full | pop);
  assign wr_drop = blk_done & full & ~pop;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      cs_d    <= 1'b0;
      acc     <= '0;
      smp_cnt <= '0;
    end else begin
      cs_d <= sample_cs;
      if (!sample_en) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else if (capture) begin
        if (blk_done) begin
          acc     <= '0;
          smp_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (wr_ok) mem[wr_ptr] <= avg;
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Bench for adc_avg_fifo: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference of the averaging FIFO.
module tb_adc_avg_fifo;
  localparam int A     = 2;
  localparam int F     = 4;
  localparam int N     = 1 << A;
  localparam int DEPTH = 1 << F;

  logic        clk_100 = 1'b0;
  logic        reset, sample_en, sample_cs, rd_en, clr_ovf;
  logic [15:0] sample_data;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, overflow;
  logic [F:0]  count;

  adc_avg_fifo #(.AVG_LOG2(A), .FIFO_LOG2(F)) dut (
    .clk_100(clk_100), .reset(reset), .sample_en(sample_en), .sample_cs(sample_cs),
    .sample_data(sample_data), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk_100 = ~clk_100;

  int q[$];
  int part[$];
  bit m_prev_cs;
  bit m_ovf;
  int m_rd_data;
  bit m_valid;
  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference, then compare all outputs.
  task automatic cyc(bit rst, bit en, bit cs, logic [15:0] d, bit rd, bit clr);
    bit wr;
    int sum;
    int avg;
    reset = rst; sample_en = en; sample_cs = cs; sample_data = d;
    rd_en = rd; clr_ovf = clr;
    wr = 0; avg = 0;
    if (rst) begin
      q.delete(); part.delete();
      m_prev_cs = 0; m_ovf = 0; m_rd_data = 0; m_valid = 0;
    end else begin
      if (!en) part.delete();
      else if (cs && !m_prev_cs) begin
        part.push_back(int'(d));
        if (part.size() == N) begin
          sum = 0;
          foreach (part[i]) sum += part[i];
          avg = sum / N;
          wr = 1;
          part.delete();
        end
      end
      m_prev_cs = cs;
      m_valid = 0;
      if (rd && q.size() > 0) begin
        m_rd_data = q.pop_front();
        m_valid = 1;
      end
      if (clr) m_ovf = 0;
      if (wr) begin
        if (q.size() < DEPTH) q.push_back(avg);
        else m_ovf = 1;
      end
    end
    @(posedge clk_100); #1;
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic pulse(logic [15:0] d, bit rd = 0);
    cyc(0, 1, 1, d, rd, 0);
    cyc(0, 1, 0, 16'h0, 0, 0);
  endtask

  task automatic word(logic [15:0] v);
    for (int i = 0; i < N; i++) pulse(v);
  endtask

  task automatic pop1();
    cyc(0, 1, 0, 16'h0, 1, 0);
  endtask

  initial begin
    reset = 1; sample_en = 0; sample_cs = 0; sample_data = 0; rd_en = 0; clr_ovf = 0;
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Basic average: 10,11,12,13 -> 11
    pulse(10); pulse(11); pulse(12);
    cyc(0, 1, 1, 16'd13, 0, 0);
    chk("avg_basic_count", 32'(count), 32'd1);
    chk("avg_basic_empty", 32'(empty), 32'd0);
    cyc(0, 1, 0, 16'h0, 0, 0);
    pop1();
    chk("avg_basic_word", 32'(rd_data), 32'd11);
    chk("avg_basic_valid", 32'(rd_valid), 32'd1);
    cyc(0, 1, 0, 16'h0, 0, 0);
    chk("rd_valid_one_cycle", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'd11);

    // Max-value and truncation
    word(16'hFFFF);
    pulse(1); pulse(1); pulse(1); pulse(2);
    pop1();
    chk("avg_max", 32'(rd_data), 32'hFFFF);
    pop1();
    chk("avg_trunc", 32'(rd_data), 32'd1);

    // Partial block discarded by sample_en low
    pulse(100); pulse(100); pulse(100);
    cyc(0, 0, 0, 16'h0, 0, 0);
    word(4);
    chk("partial_count", 32'(count), 32'd1);
    pop1();
    chk("partial_word", 32'(rd_data), 32'd4);
    pop1();
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);

    // Held chip-select is one capture; rising cs with enable low is ignored
    cyc(0, 1, 1, 16'd5, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'd5, 0, 0);
    cyc(0, 1, 0, 16'h0, 0, 0);
    pulse(9); pulse(9); pulse(9);
    pop1();
    chk("held_cs_word", 32'(rd_data), 32'd8);
    pulse(77);
    cyc(0, 0, 1, 16'd500, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);
    word(7);
    pop1();
    chk("en_low_cs_word", 32'(rd_data), 32'd7);

    // Fill, overflow, clear, drain in order
    for (int k = 1; k <= DEPTH; k++) word(16'(k));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf_clear", 32'(overflow), 32'd0);
    word(16'd17);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'(DEPTH));
    cyc(0, 1, 0, 16'h0, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      pop1();
      chk("drain_order", 32'(rd_data), 32'(k));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    pop1();
    chk("drain_extra_valid", 32'(rd_valid), 32'd0);

    // Write and pop together while full
    for (int k = 1; k <= DEPTH; k++) word(16'(k + 20));
    pulse(50); pulse(50); pulse(50);
    cyc(0, 1, 1, 16'd50, 1, 0);
    chk("full_rw_word", 32'(rd_data), 32'd21);
    chk("full_rw_count", 32'(count), 32'(DEPTH));
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    cyc(0, 1, 0, 16'h0, 0, 0);
    // clr_ovf coinciding with a dropped write leaves overflow set
    pulse(60); pulse(60); pulse(60);
    cyc(0, 1, 1, 16'd60, 0, 1);
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    cyc(0, 1, 0, 16'h0, 0, 0);

    // Reset mid-block and mid-read
    cyc(1, 0, 0, 16'h0, 0, 0);
    word(3); word(4);
    pulse(9); pulse(9); pulse(9);
    cyc(1, 1, 1, 16'd9, 1, 0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    word(6);
    chk("post_rst_count", 32'(count), 32'd1);
    pop1();
    chk("post_rst_word", 32'(rd_data), 32'd6);

    // Random traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 200) == 0, ($urandom % 8) != 0, 1'($urandom),
          16'($urandom), ($urandom % 5) == 0, ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
